// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3 slave memory model with independent read/write FSMs
module axi_slave_mem #(
    parameter int AXI_AWIDTH   = 32,
    parameter int AXI_DWIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 256,
    parameter int ADDR_LATENCY = 5
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    // write address channel
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [AXI_AWIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    // write data channel
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [AXI_DWIDTH-1:0]   WDATA,
    input  logic [AXI_DWIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // write response channel
    input  logic                    BREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    // read address channel
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [AXI_AWIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [1:0]              ARLOCK,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    // read data channel
    input  logic                    RREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [AXI_DWIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID
);

    localparam int NB        = AXI_DWIDTH / 8;
    localparam int MAXSZ     = $clog2(NB);
    localparam int MEM_BYTES = MEM_DEPTH * NB;
    localparam int BA        = $clog2(MEM_BYTES);
    localparam int WA        = BA - MAXSZ;
    localparam logic [AXI_AWIDTH-1:0] MEM_LIMIT = AXI_AWIDTH'(MEM_BYTES);
    localparam logic [3:0]            LAT_INIT  = 4'(ADDR_LATENCY);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Address of the next beat; INCR realigns after an unaligned first beat.
    function automatic logic [AXI_AWIDTH-1:0] next_addr(
        input logic [AXI_AWIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [3:0]            len
    );
        logic [AXI_AWIDTH-1:0] incr;
        logic [AXI_AWIDTH-1:0] mask;
        incr = AXI_AWIDTH'(1) << size;
        mask = ((AXI_AWIDTH'(len) + AXI_AWIDTH'(1)) << size) - AXI_AWIDTH'(1);
        case (burst)
            2'b01:   next_addr = (addr & ~(incr - AXI_AWIDTH'(1))) + incr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    // Commands that make every beat of the burst an error.
    function automatic logic cmd_illegal(
        input logic [AXI_AWIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [3:0]            len
    );
        logic [AXI_AWIDTH-1:0] incr;
        incr = AXI_AWIDTH'(1) << size;
        cmd_illegal = (size > 3'(MAXSZ))
                   || (burst == 2'b11)
                   || ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}))
                   || ((burst == 2'b10) && ((addr & (incr - AXI_AWIDTH'(1))) != '0));
    endfunction

    function automatic logic in_range(input logic [AXI_AWIDTH-1:0] addr);
        in_range = addr < MEM_LIMIT;
    endfunction

    function automatic logic [WA-1:0] word_idx(input logic [AXI_AWIDTH-1:0] addr);
        word_idx = addr[BA-1:MAXSZ];
    endfunction

    logic [AXI_DWIDTH-1:0] mem_q [MEM_DEPTH];

    // Lock signals carry no meaning for this model.
    logic unused_lock;
    assign unused_lock = ^{AWLOCK, ARLOCK};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wstate_t               wstate_q, wstate_d;
    logic [3:0]            wlat_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [AXI_AWIDTH-1:0] waddr_q;
    logic [3:0]            wlen_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic [3:0]            wbeat_q;
    logic                  werr_q;
    logic                  willegal_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  w_last_beat;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign BID         = wid_q;
    assign BRESP       = werr_q ? 2'b10 : 2'b00;

    // Write FSM next-state and handshake outputs.
    always_comb begin
        wstate_d = wstate_q;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        case (wstate_q)
            W_IDLE: if (AWVALID) wstate_d = W_WAIT;
            W_WAIT: begin
                if (wlat_q == 4'd0) begin
                    AWREADY  = 1'b1;
                    wstate_d = AWVALID ? W_DATA : W_IDLE;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last_beat) wstate_d = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wstate_q <= W_IDLE;
        else        wstate_q <= wstate_d;
    end

    // Write command latch, latency counter, beat tracking and error flag.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wlat_q     <= 4'd0;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= 4'd0;
            wsize_q    <= 3'd0;
            wburst_q   <= 2'd0;
            wbeat_q    <= 4'd0;
            werr_q     <= 1'b0;
            willegal_q <= 1'b0;
        end else begin
            if (wstate_q == W_IDLE && AWVALID)
                wlat_q <= LAT_INIT;
            else if (wstate_q == W_WAIT && wlat_q != 4'd0)
                wlat_q <= wlat_q - 4'd1;

            if (aw_hs) begin
                wid_q      <= AWID;
                waddr_q    <= AWADDR;
                wlen_q     <= AWLEN;
                wsize_q    <= AWSIZE;
                wburst_q   <= AWBURST;
                wbeat_q    <= 4'd0;
                werr_q     <= cmd_illegal(AWADDR, AWSIZE, AWBURST, AWLEN);
                willegal_q <= cmd_illegal(AWADDR, AWSIZE, AWBURST, AWLEN);
            end else if (w_hs) begin
                werr_q  <= werr_q || !in_range(waddr_q)
                                  || (WLAST != w_last_beat)
                                  || (WID != wid_q);
                waddr_q <= next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                wbeat_q <= wbeat_q + 4'd1;
            end
        end
    end

    // Byte-lane memory write; the array keeps its contents across reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && !willegal_q && in_range(waddr_q)) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rstate_t               rstate_q, rstate_d;
    logic [3:0]            rlat_q;
    logic [AXI_AWIDTH-1:0] raddr_q;
    logic [3:0]            rlen_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic [3:0]            rbeat_q;
    logic                  rillegal_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [AXI_DWIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic                  rvalid_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  ar_illegal;

    assign ar_hs      = ARVALID && ARREADY;
    assign r_hs       = rvalid_q && RREADY;
    assign ar_illegal = cmd_illegal(ARADDR, ARSIZE, ARBURST, ARLEN);
    assign RID        = rid_q;
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign RLAST      = rlast_q;
    assign RVALID     = rvalid_q;

    // Read FSM next-state and address-ready output.
    always_comb begin
        rstate_d = rstate_q;
        ARREADY  = 1'b0;
        case (rstate_q)
            R_IDLE: if (ARVALID) rstate_d = R_WAIT;
            R_WAIT: begin
                if (rlat_q == 4'd0) begin
                    ARREADY  = 1'b1;
                    rstate_d = ARVALID ? R_DATA : R_IDLE;
                end
            end
            R_DATA: if (r_hs && rlast_q) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rstate_q <= R_IDLE;
        else        rstate_q <= rstate_d;
    end

    // Read command latch and registered beat presentation; memory is sampled
    // before any same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rlat_q     <= 4'd0;
            raddr_q    <= '0;
            rlen_q     <= 4'd0;
            rsize_q    <= 3'd0;
            rburst_q   <= 2'd0;
            rbeat_q    <= 4'd0;
            rillegal_q <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            if (rstate_q == R_IDLE && ARVALID)
                rlat_q <= LAT_INIT;
            else if (rstate_q == R_WAIT && rlat_q != 4'd0)
                rlat_q <= rlat_q - 4'd1;

            if (ar_hs) begin
                rid_q      <= ARID;
                rlen_q     <= ARLEN;
                rsize_q    <= ARSIZE;
                rburst_q   <= ARBURST;
                rillegal_q <= ar_illegal;
                raddr_q    <= next_addr(ARADDR, ARSIZE, ARBURST, ARLEN);
                rbeat_q    <= 4'd1;
                rlast_q    <= (ARLEN == 4'd0);
                rvalid_q   <= 1'b1;
                if (!ar_illegal && in_range(ARADDR)) begin
                    rdata_q <= mem_q[word_idx(ARADDR)];
                    rresp_q <= 2'b00;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= 2'b10;
                end
            end else if (r_hs) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    raddr_q <= next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                    rbeat_q <= rbeat_q + 4'd1;
                    rlast_q <= (rbeat_q == rlen_q);
                    if (!rillegal_q && in_range(raddr_q)) begin
                        rdata_q <= mem_q[word_idx(raddr_q)];
                        rresp_q <= 2'b00;
                    end else begin
                        rdata_q <= '0;
                        rresp_q <= 2'b10;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - directed self-checking bench for axi_slave_mem
module tb_axi_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic        BREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [1:0]  ARLOCK;
    logic        ARVALID;
    logic        ARREADY;
    logic        RREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;

    axi_slave_mem #(
        .AXI_AWIDTH(32), .AXI_DWIDTH(64), .ID_WIDTH(4),
        .MEM_DEPTH(256), .ADDR_LATENCY(5)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BREADY(BREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    int          wr_lat;
    int          rd_lat;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_bid;
    logic [63:0] wr_data [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [63:0] d       [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input logic [3:0] wid,
                             input logic [7:0] strb, input int bstall);
        int guard;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wr_lat = 0; guard = 0;
        while (!AWREADY && guard < 100) begin
            @(posedge ACLK); #1; wr_lat++; guard++;
        end
        if (!AWREADY) check("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WID = wid; WDATA = wr_data[i]; WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
            guard = 0;
            while (!WREADY && guard < 100) begin
                @(posedge ACLK); #1; guard++;
            end
            if (!WREADY) check("w_timeout", 0, 1);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        guard = 0;
        while (!BVALID && guard < 100) begin
            @(posedge ACLK); #1; guard++;
        end
        if (!BVALID) check("b_timeout", 0, 1);
        for (int s = 0; s < bstall; s++) begin
            @(posedge ACLK); #1;
            check("b_hold", BVALID, 1);
        end
        wr_resp = BRESP; wr_bid = BID;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id,
                            input int stall_beat, input int abort_beat);
        int guard;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        rd_lat = 0; guard = 0;
        while (!ARREADY && guard < 100) begin
            @(posedge ACLK); #1; rd_lat++; guard++;
        end
        if (!ARREADY) check("ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            guard = 0;
            while (!RVALID && guard < 100) begin
                @(posedge ACLK); #1; guard++;
            end
            if (!RVALID) check("r_timeout", 0, 1);
            if (i == abort_beat) begin
                ARESET = 1'b1;
                #1;
                check("rst_rvalid", RVALID, 0);
                check("rst_rlast", RLAST, 0);
                ARESET = 1'b0;
                RREADY = 1'b0;
                return;
            end
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id[i] = RID;
            if (i == stall_beat) begin
                RREADY = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    @(posedge ACLK); #1;
                    check("stall_valid", RVALID, 1);
                    check("stall_data", RDATA, rd_data[i]);
                    check("stall_last", RLAST, rd_last[i]);
                end
                RREADY = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        RREADY = 1'b0;
        check("rvalid_end", RVALID, 0);
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWLOCK = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARLOCK = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hFEDC_BA98_7654_3210;
        d[2] = 64'hA5A5_5A5A_0F0F_F0F0;
        d[3] = 64'h1111_2222_3333_4444;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}, 6'b0);
        check("rst_bresp", BRESP, 2'b00);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        // INCR write/read, latency and IDs
        wr_data[0] = 64'h11; wr_data[1] = 64'h22; wr_data[2] = 64'h33; wr_data[3] = 64'h44;
        axi_write(32'h10, 4'd3, 3'd3, 2'b01, 4'd5, 4'd5, 8'hFF, 0);
        check("aw_latency", wr_lat, 6);
        check("incr_bresp", wr_resp, 2'b00);
        check("incr_bid", wr_bid, 4'd5);
        axi_read(32'h10, 4'd3, 3'd3, 2'b01, 4'd3, -1, -1);
        check("ar_latency", rd_lat, 6);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rd_data[i], wr_data[i]);
            check("incr_rresp", rd_resp[i], 2'b00);
            check("incr_rlast", rd_last[i], (i == 3));
            check("incr_rid", rd_id[i], 4'd3);
        end

        // WRAP read crosses the 32-byte boundary
        for (int i = 0; i < 4; i++) wr_data[i] = d[i];
        axi_write(32'h0, 4'd3, 3'd3, 2'b01, 4'd1, 4'd1, 8'hFF, 0);
        axi_read(32'h18, 4'd3, 3'd3, 2'b10, 4'd2, -1, -1);
        check("wrap_b0", rd_data[0], d[3]);
        check("wrap_b1", rd_data[1], d[0]);
        check("wrap_b2", rd_data[2], d[1]);
        check("wrap_b3", rd_data[3], d[2]);
        check("wrap_rresp", rd_resp[3], 2'b00);

        // byte strobes
        wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(32'h0, 4'd0, 3'd3, 2'b01, 4'd1, 4'd1, 8'hFF, 0);
        wr_data[0] = 64'h0;
        axi_write(32'h0, 4'd0, 3'd3, 2'b01, 4'd1, 4'd1, 8'h0F, 0);
        axi_read(32'h0, 4'd0, 3'd3, 2'b01, 4'd1, -1, -1);
        check("strb_rdata", rd_data[0], 64'hFFFF_FFFF_0000_0000);
        check("strb_rlast", rd_last[0], 1'b1);

        // top of memory: second beat is out of range
        wr_data[0] = 64'hBEEF; wr_data[1] = 64'h1234;
        axi_write(32'h7F8, 4'd1, 3'd3, 2'b01, 4'd2, 4'd2, 8'hFF, 0);
        check("oor_bresp", wr_resp, 2'b10);
        axi_read(32'h7F8, 4'd1, 3'd3, 2'b01, 4'd2, -1, -1);
        check("oor_b0_data", rd_data[0], 64'hBEEF);
        check("oor_b0_resp", rd_resp[0], 2'b00);
        check("oor_b1_data", rd_data[1], 64'h0);
        check("oor_b1_resp", rd_resp[1], 2'b10);

        // oversize write is rejected and leaves memory alone
        wr_data[0] = 64'hDEAD;
        axi_write(32'h10, 4'd0, 3'd4, 2'b01, 4'd6, 4'd6, 8'hFF, 0);
        check("size_bresp", wr_resp, 2'b10);
        check("size_bid", wr_bid, 4'd6);
        axi_read(32'h10, 4'd0, 3'd3, 2'b01, 4'd6, -1, -1);
        check("size_mem", rd_data[0], d[2]);

        // WRAP with length 3 beats is illegal
        axi_read(32'h0, 4'd2, 3'd3, 2'b10, 4'd4, -1, -1);
        check("wraplen_data", rd_data[1], 64'h0);
        check("wraplen_resp0", rd_resp[0], 2'b10);
        check("wraplen_resp2", rd_resp[2], 2'b10);
        check("wraplen_last", rd_last[2], 1'b1);

        // WID mismatch flags SLVERR
        wr_data[0] = 64'h77;
        axi_write(32'h20, 4'd0, 3'd3, 2'b01, 4'd3, 4'd9, 8'hFF, 0);
        check("wid_bresp", wr_resp, 2'b10);

        // FIXED burst rewrites one word
        wr_data[0] = 64'hAAAA; wr_data[1] = 64'hBBBB;
        axi_write(32'h40, 4'd1, 3'd3, 2'b00, 4'd1, 4'd1, 8'hFF, 0);
        axi_read(32'h40, 4'd0, 3'd3, 2'b01, 4'd1, -1, -1);
        check("fixed_rdata", rd_data[0], 64'hBBBB);

        // RREADY stall, then BREADY stall
        axi_read(32'h08, 4'd1, 3'd3, 2'b01, 4'd8, 1, -1);
        check("stall_b0", rd_data[0], d[1]);
        check("stall_b1", rd_data[1], d[2]);
        check("stall_last1", rd_last[1], 1'b1);
        wr_data[0] = 64'h55;
        axi_write(32'h30, 4'd0, 3'd3, 2'b01, 4'd7, 4'd7, 8'hFF, 4);
        check("bstall_bresp", wr_resp, 2'b00);
        check("bstall_bid", wr_bid, 4'd7);

        // reset mid-burst, memory survives
        axi_read(32'h0, 4'd3, 3'd3, 2'b01, 4'd1, -1, 2);
        check("abort_b0", rd_data[0], 64'hFFFF_FFFF_0000_0000);
        @(posedge ACLK); #1;
        check("post_rst_idle", {ARREADY, RVALID, AWREADY, BVALID}, 4'b0);
        axi_read(32'h08, 4'd0, 3'd3, 2'b01, 4'd2, -1, -1);
        check("persist_08", rd_data[0], d[1]);
        axi_read(32'h30, 4'd0, 3'd3, 2'b01, 4'd2, -1, -1);
        check("persist_30", rd_data[0], 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Parametrised, synthesizable AXI3 slave memory model for block and system benches.
- Next generation of the task-driven AXI slave stub.
- Independent read and write FSMs, a byte-addressable backing memory, FIXED/INCR/WRAP bursts, WSTRB byte enables, programmable address-accept latency and SLVERR on illegal or out-of-range accesses.
- Sits on the AXI side of the AHB-Lite-to-AXI bridge in place of the stub.

Parameters:
- AXI_AWIDTH, 32, address width.
- AXI_DWIDTH, 64, data width; 32, 64 or 128.
- ID_WIDTH, 4, width of AWID/WID/BID/ARID/RID.
- MEM_DEPTH, 256, memory depth in AXI_DWIDTH words; power of 2.
- ADDR_LATENCY, 5, idle cycles inserted before AWREADY/ARREADY; 0..15.
- Derived: NB = AXI_DWIDTH/8; MAXSZ = log2(NB); MEM_BYTES = MEM_DEPTH*NB.

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous active-high reset
- AWID AWADDR AWLEN AWSIZE AWBURST AWLOCK AWVALID  in  ID_WIDTH/AXI_AWIDTH/4/3/2/2/1  write address channel
- AWREADY  out  1  write address accept
- WID WDATA WSTRB WLAST WVALID  in  ID_WIDTH/AXI_DWIDTH/NB/1/1  write data channel
- WREADY  out  1  write data accept
- BREADY  in  1  response accept
- BID BRESP BVALID  out  ID_WIDTH/2/1  write response channel
- ARID ARADDR ARLEN ARSIZE ARBURST ARLOCK ARVALID  in  ID_WIDTH/AXI_AWIDTH/4/3/2/2/1  read address channel
- ARREADY  out  1  read address accept
- RREADY  in  1  read data accept
- RID RDATA RRESP RLAST RVALID  out  ID_WIDTH/AXI_DWIDTH/2/1/1  read data channel

Behaviour:
- Reset: all outputs, counters and FSMs go to 0/IDLE asynchronously, including when a burst is in progress. A partially transferred burst is abandoned and no response is issued. Memory array is not reset; contents persist across reset.
- Write FSM states: W_IDLE, W_WAIT, W_DATA, W_RESP.
  - W_IDLE with AWVALID: load latency counter with ADDR_LATENCY, go to W_WAIT.
  - W_WAIT: decrement the counter. At 0, drive AWREADY high for exactly one cycle. Latency is ADDR_LATENCY+1 cycles from first sampled AWVALID to AWREADY.
  - On the AW handshake: latch ID, address, length, size and burst; clear the beat counter and error flag; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY beat writes WDATA byte lanes where WSTRB=1 to word addr[log2(MEM_BYTES)-1:MAXSZ], only if addr < MEM_BYTES and the beat is legal. Then advance addr and the beat counter.
  - After beat AWLEN: WREADY=0 the next cycle; go to W_RESP.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b10 if the error flag is set, else 2'b00. Hold until BREADY, then go to W_IDLE.
  - Error flag sets on: any out-of-range beat; WLAST != (beat==AWLEN); WID != latched ID; illegal command.
- Read FSM states: R_IDLE, R_WAIT, R_DATA. Address phase is identical to the write side, using ARVALID/ARREADY.
  - R_DATA: load RDATA/RRESP/RLAST/RID registers, RVALID=1. Outputs stay stable while RVALID&&!RREADY.
  - On the handshake, the next beat is presented the following cycle (RVALID stays high, one beat per cycle under continuous RREADY).
  - RLAST=1 only on beat ARLEN. After the last handshake: RVALID=0, RLAST=0, go to R_IDLE.
  - RDATA is the full memory word at the beat address. For out-of-range or illegal beats, RDATA=0 and RRESP=2'b10; otherwise RRESP=2'b00.
- Illegal command (all beats SLVERR, no memory write): size > MAXSZ; burst 2'b11; WRAP with len not in {1,3,7,15}; WRAP address not aligned to size.
- Address update per beat, with incr = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+incr, modulo 2^AXI_AWIDTH.
  - WRAP: bound=(len+1)*incr; addr = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
  - Unaligned INCR start: first beat uses the given address; later beats align to incr.
- Read and write channels run fully concurrently. When a read beat loads in the same cycle as a write to the same word, the read returns pre-write data.
- AWLOCK/ARLOCK are accepted and ignored; EXOKAY is never returned.

Test Plan:
- ADDR_LATENCY=5, INCR write AWADDR=0x10, AWLEN=3, size 3, data 0x11..44 -> AWREADY 6 cycles after AWVALID; BRESP=00, BID=AWID. INCR read of the same range returns 0x11,0x22,0x33,0x44 with RLAST only on beat 3.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then write 0x0 with WSTRB=0x0F -> read 0x0 returns 0xFFFF_FFFF_0000_0000.
- WRAP read ARADDR=0x18, ARLEN=3, size 3 -> beat addresses 0x18, 0x00, 0x08, 0x10.
- Read ARADDR=MEM_BYTES-8, ARLEN=1 -> beat0 RRESP=00, beat1 RRESP=10 with RDATA=0. Write ARSIZE=4 at DWIDTH 64 -> BRESP=10, memory unchanged.
- Read with RREADY toggling 1,0,0,1 -> RDATA/RLAST held stable while stalled. Write with BREADY low for 4 cycles -> BVALID held.
- ARESET pulsed during beat 2 of a 4-beat read -> RVALID=0 asynchronously; a new read after reset returns the previously written data.
